// File: rtl/imem_dbg_port_arbiter.sv
// Arbitrates the instruction-RAM debug port B between the debug host (0) and the program loader (1).
// One transaction at a time: IDLE -> ISSUE -> (RDWAIT) -> RESP, with WE2 live only during ISSUE.
module imem_dbg_port_arbiter #(
    parameter int RR_EN = 1,
    parameter int AW    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [7:0]        req_we,
    input  logic [2*AW-1:0]   req_addr,
    input  logic [63:0]       req_wdata,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              busy,
    output logic [AW-1:0]     A2,
    output logic [31:0]       WD2,
    output logic [3:0]        WE2,
    input  logic [31:0]       RD2
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_gnt;
    logic          owner;
    logic          winner;
    logic          grant;
    logic [AW-1:0] win_addr;
    logic [31:0]   win_wdata;
    logic [3:0]    win_we;

    always_comb begin
        winner = 1'b0;
        case (req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = (RR_EN != 0) ? ~last_gnt : 1'b0;
            default: winner = 1'b0;
        endcase

        // rst_n gates the grant so req_ready reads zero throughout reset
        grant     = rst_n && (state == IDLE) && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end

        win_addr  = winner ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
        win_wdata = winner ? req_wdata[63:32]    : req_wdata[31:0];
        win_we    = winner ? req_we[7:4]         : req_we[3:0];

        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = (WE2 != 4'h0) ? RESP : RDWAIT;
            RDWAIT:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        rsp_valid = 2'b00;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            A2        <= '0;
            WD2       <= 32'h0;
            WE2       <= 4'h0;
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            rsp_rdata <= 32'h0;
        end else begin
            state <= state_nxt;
            // Clearing WE2 on every non-grant edge confines it to the single ISSUE cycle
            if (grant) begin
                A2        <= win_addr;
                WD2       <= win_wdata;
                WE2       <= win_we;
                owner     <= winner;
                last_gnt  <= winner;
                rsp_rdata <= 32'h0;
            end else begin
                WE2 <= 4'h0;
            end
            if (state == RDWAIT) begin
                rsp_rdata <= RD2;
            end
        end
    end

endmodule

// File: tb/tb_imem_dbg_port_arbiter.sv
// Bench for imem_dbg_port_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own RAM behind port B, checked against a transaction-level reference model.
module tb_imem_dbg_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [7:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic [1:0]  rdy  [2];
    logic [1:0]  rv   [2];
    logic [31:0] rdat [2];
    logic        bsy  [2];
    logic [31:0] a2   [2];
    logic [31:0] wd2  [2];
    logic [3:0]  we2  [2];
    logic [31:0] rd2  [2];

    logic [31:0] ram [2][256];
    logic        init_ram;

    always #5 clk = ~clk;

    imem_dbg_port_arbiter #(.RR_EN(1), .AW(32)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[0]),
        .rsp_valid(rv[0]), .rsp_rdata(rdat[0]), .busy(bsy[0]),
        .A2(a2[0]), .WD2(wd2[0]), .WE2(we2[0]), .RD2(rd2[0])
    );

    imem_dbg_port_arbiter #(.RR_EN(0), .AW(32)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[1]),
        .rsp_valid(rv[1]), .rsp_rdata(rdat[1]), .busy(bsy[1]),
        .A2(a2[1]), .WD2(wd2[1]), .WE2(we2[1]), .RD2(rd2[1])
    );

    // Synchronous RAM with byte enables and one-cycle read latency
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (init_ram) begin
                for (int j = 0; j < 256; j++) ram[k][j] <= 32'h0;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (we2[k][b]) ram[k][a2[k][9:2]][8*b +: 8] <= wd2[k][8*b +: 8];
                end
            end
            rd2[k] <= ram[k][a2[k][9:2]];
        end
    end

    // Reference model: transaction scheduling in absolute cycle numbers
    int          cyc;
    int          m_free [2];
    int          m_last [2];
    int          m_iss  [2];
    int          m_rsp  [2];
    int          m_own  [2];
    logic [3:0]  m_we   [2];
    logic [31:0] m_a2   [2];
    logic [31:0] m_wd2  [2];
    logic [31:0] m_rdata[2];
    logic [31:0] m_mem  [2][256];

    int n_tests;
    int n_fail;
    bit rec;
    int g_hist [2][16];
    int g_cnt  [2];

    typedef struct {
        logic [1:0]  v;
        logic [7:0]  we;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [1:0]  e_rdy;
        logic [3:0]  e_we2;
        logic [31:0] e_a2;
        logic [31:0] e_wd2;
        logic        e_busy;
        logic [1:0]  e_rv;
        logic [31:0] e_rd;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s @cyc %0d: got %0h, expected %0h", k, nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_free[k] = 0;
        m_last[k] = 1;
        m_iss[k]  = -1;
        m_rsp[k]  = -1;
        m_own[k]  = 0;
        m_we[k]   = 4'h0;
        m_a2[k]   = 32'h0;
        m_wd2[k]  = 32'h0;
        m_rdata[k] = 32'h0;
    endtask

    function automatic int pick(input int k);
        if (req_valid == 2'b01) return 0;
        if (req_valid == 2'b10) return 1;
        return (k == 0) ? 1 - m_last[k] : 0;
    endfunction

    task automatic step_model(input int k);
        bit          idle;
        int          w;
        logic [1:0]  erv;
        logic [31:0] wa;
        idle = (cyc >= m_free[k]);
        w = -1;
        if (idle && req_valid != 2'b00) w = pick(k);
        if (rec && rdy[k] != 2'b00 && g_cnt[k] < 16) begin
            g_hist[k][g_cnt[k]] = (rdy[k] == 2'b10) ? 1 : 0;
            g_cnt[k]++;
        end
        chk(k, "req_ready", rdy[k], (w >= 0) ? (2'b01 << w) : 2'b00);
        chk(k, "busy", bsy[k], !idle);
        chk(k, "WE2", we2[k], (cyc == m_iss[k]) ? m_we[k] : 4'h0);
        chk(k, "A2", a2[k], m_a2[k]);
        chk(k, "WD2", wd2[k], m_wd2[k]);
        erv = (cyc == m_rsp[k]) ? (2'b01 << m_own[k]) : 2'b00;
        chk(k, "rsp_valid", rv[k], erv);
        if (erv != 2'b00) chk(k, "rsp_rdata", rdat[k], m_rdata[k]);
        if (cyc == m_iss[k]) begin
            for (int b = 0; b < 4; b++)
                if (m_we[k][b]) m_mem[k][m_a2[k][9:2]][8*b +: 8] = m_wd2[k][8*b +: 8];
        end
        if (w >= 0) begin
            wa        = req_addr[32*w +: 32];
            m_a2[k]   = wa;
            m_wd2[k]  = req_wdata[32*w +: 32];
            m_we[k]   = req_we[4*w +: 4];
            m_own[k]  = w;
            m_last[k] = w;
            m_iss[k]  = cyc + 1;
            if (m_we[k] != 4'h0) begin
                m_rsp[k]   = cyc + 2;
                m_free[k]  = cyc + 3;
                m_rdata[k] = 32'h0;
            end else begin
                m_rsp[k]   = cyc + 3;
                m_free[k]  = cyc + 4;
                m_rdata[k] = m_mem[k][wa[9:2]];
            end
        end
    endtask

    task automatic tick(input int row);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (row >= 0) begin
                chk(k, $sformatf("tbl%0d req_ready", row), rdy[k], tbl[row].e_rdy);
                chk(k, $sformatf("tbl%0d WE2", row), we2[k], tbl[row].e_we2);
                chk(k, $sformatf("tbl%0d A2", row), a2[k], tbl[row].e_a2);
                chk(k, $sformatf("tbl%0d WD2", row), wd2[k], tbl[row].e_wd2);
                chk(k, $sformatf("tbl%0d busy", row), bsy[k], tbl[row].e_busy);
                chk(k, $sformatf("tbl%0d rsp_valid", row), rv[k], tbl[row].e_rv);
                if (tbl[row].e_rv != 2'b00)
                    chk(k, $sformatf("tbl%0d rsp_rdata", row), rdat[k], tbl[row].e_rd);
            end
            step_model(k);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] we, input logic [63:0] addr, input logic [63:0] wd);
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic chk_all_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk(k, {nm, " req_ready"}, rdy[k], 2'b00);
            chk(k, {nm, " rsp_valid"}, rv[k], 2'b00);
            chk(k, {nm, " busy"}, bsy[k], 1'b0);
            chk(k, {nm, " WE2"}, we2[k], 4'h0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rec     = 1'b0;
        g_cnt[0] = 0;
        g_cnt[1] = 0;
        rst_n    = 1'b0;
        init_ram = 1'b1;
        drive(2'b00, 8'h00, 64'h0, 64'h0);
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            for (int j = 0; j < 256; j++) m_mem[k][j] = 32'h0;
        end

        //                 v      we     addr                    wd            rdy    we2   a2     wd2           busy  rv     rd
        tbl[0] = '{2'b01, 8'h0F, 64'h10,                 64'hDEADBEEF, 2'b01, 4'h0, 32'h0,  32'h0,        1'b0, 2'b00, 32'h0};
        tbl[1] = '{2'b00, 8'h00, 64'h0,                  64'h0,        2'b00, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 2'b00, 32'h0};
        tbl[2] = '{2'b00, 8'h00, 64'h0,                  64'h0,        2'b00, 4'h0, 32'h10, 32'hDEADBEEF, 1'b1, 2'b01, 32'h0};
        tbl[3] = '{2'b10, 8'h00, 64'h0000_0010_0000_0000, 64'h0,       2'b10, 4'h0, 32'h10, 32'hDEADBEEF, 1'b0, 2'b00, 32'h0};
        tbl[4] = '{2'b00, 8'h00, 64'h0,                  64'h0,        2'b00, 4'h0, 32'h10, 32'h0,        1'b1, 2'b00, 32'h0};
        tbl[5] = '{2'b00, 8'h00, 64'h0,                  64'h0,        2'b00, 4'h0, 32'h10, 32'h0,        1'b1, 2'b00, 32'h0};
        tbl[6] = '{2'b00, 8'h00, 64'h0,                  64'h0,        2'b00, 4'h0, 32'h10, 32'h0,        1'b1, 2'b10, 32'hDEADBEEF};
        tbl[7] = '{2'b00, 8'h00, 64'h0,                  64'h0,        2'b00, 4'h0, 32'h10, 32'h0,        1'b0, 2'b00, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        for (int k = 0; k < 2; k++) begin
            chk(k, "reset A2", a2[k], 32'h0);
            chk(k, "reset WD2", wd2[k], 32'h0);
            chk(k, "reset rsp_rdata", rdat[k], 32'h0);
        end
        init_ram = 1'b0;
        rst_n    = 1'b1;

        repeat (10) tick(-1);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].we, tbl[i].addr, tbl[i].wd);
            tick(i);
        end

        // Preload 0x0 and 0x4, then both requesters read continuously
        drive(2'b01, 8'h0F, 64'h0, 64'hA5A5_0000);
        tick(-1);
        drive(2'b00, 8'h00, 64'h0, 64'h0);
        repeat (2) tick(-1);
        drive(2'b10, 8'hF0, 64'h0000_0004_0000_0000, 64'h5A5A_1111_0000_0000);
        tick(-1);
        drive(2'b00, 8'h00, 64'h0, 64'h0);
        repeat (2) tick(-1);
        rec = 1'b1;
        drive(2'b11, 8'h00, 64'h0000_0004_0000_0000, 64'h0);
        repeat (24) tick(-1);
        rec = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk(k, "contention grant count", g_cnt[k], 6);
            for (int i = 0; i < 6 && i < g_cnt[k]; i++)
                chk(k, $sformatf("contention grant %0d", i), g_hist[k][i], (k == 0) ? (i % 2) : 0);
        end

        // Requester 1 asks while busy and withdraws before IDLE
        drive(2'b00, 8'h00, 64'h0, 64'h0);
        repeat (4) tick(-1);
        drive(2'b01, 8'h0F, 64'h20, 64'hCAFE_F00D);
        tick(-1);
        drive(2'b10, 8'h00, 64'h0000_0020_0000_0000, 64'h0);
        repeat (2) tick(-1);
        drive(2'b00, 8'h00, 64'h0, 64'h0);
        repeat (4) tick(-1);

        // Reset during the ISSUE cycle of a partial write
        drive(2'b01, 8'h03, 64'h40, 64'h1234_5678);
        tick(-1);
        drive(2'b00, 8'h00, 64'h0, 64'h0);
        for (int k = 0; k < 2; k++) chk(k, "issue WE2 before abort", we2[k], 4'h3);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k);
        repeat (3) tick(-1);
        drive(2'b11, 8'h00, 64'h0000_0040_0000_0040, 64'h0);
        tick(-1);
        drive(2'b00, 8'h00, 64'h0, 64'h0);
        repeat (4) tick(-1);

        for (int n = 0; n < 400; n++) begin
            req_valid = 2'($urandom);
            req_we    = {($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                         ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0};
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            tick(-1);
        end
        drive(2'b00, 8'h00, 64'h0, 64'h0);
        repeat (5) tick(-1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_dbg_port_arbiter.md
Name: imem_dbg_port_arbiter

Overview:
- Shares the instruction RAM debug port (port B: A2/WD2/WE2/RD2 of the IF-ID stage) between two requesters:
  - requester 0: debug host;
  - requester 1: program loader.
- Per-requester valid/ready request handshake and one-cycle response pulse.
- Sequences the RAM's 1-cycle synchronous read latency and guarantees WE2 is non-zero only for exactly one cycle per accepted write.
- Sits between the debug/loader logic and the IF-ID segment register; the CPU fetch port A is untouched.

Parameters:
- RR_EN, 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.
- AW, 32: address width of requests and of A2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  request valid per requester (bit i = requester i)
- req_we  in  8  byte enables; [4i+3:4i] for requester i; all-zero = read
- req_addr  in  2*AW  byte address; [AW*i+AW-1:AW*i] for requester i
- req_wdata  in  64  write data; [32i+31:32i] for requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- rsp_valid  out  2  one-cycle completion pulse per requester
- rsp_rdata  out  32  read data, valid while any rsp_valid bit is high
- busy  out  1  high in any state other than IDLE
- A2  out  AW  RAM port-B address (byte address; RAM uses A2[AW-1:2])
- WD2  out  32  RAM port-B write data
- WE2  out  4  RAM port-B byte write enables
- RD2  in  32  RAM port-B read data, valid one cycle after the address cycle

Behaviour:
- Reset (async, rst_n low), all outputs zero:
  - state = IDLE; A2 = 0; WD2 = 0; WE2 = 0; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; busy = 0.
  - Round-robin pointer favours requester 0.
  - Reset mid-transaction aborts it with no response; WE2 drops immediately.
- States: IDLE -> ISSUE -> (RDWAIT if read) -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational and asserted for the winner only when state = IDLE and its req_valid = 1.
  - At the clock edge the winner's addr/we/wdata are registered into A2/WE2/WD2 and the state moves to ISSUE.
  - With no valid request: stay in IDLE, WE2 = 0.
- Arbitration:
  - RR_EN = 1, both valid: grant the requester not granted last; the pointer updates only on a grant.
  - RR_EN = 0: requester 0 always wins a tie.
  - A single valid requester is always granted, regardless of pointer.
- ISSUE (one cycle):
  - A2/WD2/WE2 drive the RAM; the RAM samples at the end of this cycle.
  - Write (WE2 != 0) -> RESP. Read -> RDWAIT.
- RDWAIT (one cycle): WE2 = 0; RD2 is valid. rsp_rdata <= RD2 at the edge; then -> RESP.
- RESP (one cycle):
  - rsp_valid[owner] = 1, all other bits 0; busy = 1; then -> IDLE.
  - For writes, rsp_rdata = 0.
- Outside ISSUE:
  - WE2 = 0 always.
  - A2 and WD2 hold their last values; no spurious writes.
- Latency from accepting edge to rsp_valid high:
  - write: 2 cycles;
  - read: 3 cycles.
- Throughput: one transaction per 3 cycles (write) or 4 cycles (read), IDLE cycle included.
- Requester behaviour:
  - Requesters may drop req_valid at any time before req_ready. A dropped request is never granted.
  - Requests arriving while busy wait; req_ready stays 0.
- A requester reasserting req_valid in its own RESP cycle is not granted in that cycle; it is eligible in the following IDLE, and round-robin favours the other requester if both are valid.
- Addresses are passed through unmodified; A2[1:0] is ignored by the RAM. No alignment checking.

Test Plan:
- Reset then idle:
  - All outputs 0.
  - Hold rst_n = 1 for 10 cycles with req_valid = 0 -> WE2 never non-zero, busy = 0.
- Single write by requester 0, addr 0x0000_0010, wdata 0xDEADBEEF, we 0xF:
  - req_ready[0] for 1 cycle.
  - Next cycle: A2 = 0x10, WE2 = 0xF, WD2 = 0xDEADBEEF for exactly 1 cycle.
  - rsp_valid[0] 2 cycles after accept.
- Read back by requester 1, addr 0x10:
  - rsp_valid[1] 3 cycles after accept, rsp_rdata = 0xDEADBEEF, rsp_valid[0] = 0.
  - WE2 = 0 throughout.
- Contention, RR_EN = 1, both requesters continuously issue reads to 0x0 and 0x4:
  - Grants alternate 0,1,0,1.
  - Each response carries its own address's data.
  - With RR_EN = 0, requester 0 wins every tie.
- Reset mid-operation: assert rst_n = 0 during ISSUE of a write with we = 0x3:
  - WE2 drops to 0 asynchronously; no rsp_valid.
  - After release: state IDLE, pointer favours requester 0.
- Request withdrawal: requester 1 raises req_valid while busy, then drops it before IDLE -> never granted, no response.
